// File: rtl/river_pkg.sv
// Shared types and helpers for the river crossing puzzle controller.
//   state_t          : game state encoding (PLAY, WIN, LOSE)
//   CONFLICT_DEFAULT : predator/prey mask for the classic fox/chicken/seed game
//   popcount         : number of set bits in a 32-bit vector
package river_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    WIN  = 2'd1,
    LOSE = 2'd2
  } state_t;

  // Bit i*3+j: item i eats item j. Fox(2) eats chicken(1), chicken(1) eats seed(0).
  localparam logic [8:0] CONFLICT_DEFAULT = 9'h088;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/crossing_checker.sv
// Combinational move evaluator.
//   pos        : current bank vector {farmer, items}
//   move_pos   : requested bank vector
//   legal      : farmer crosses, carried items ride with him, load <= BOAT_CAP
//   conflict   : in move_pos some predator sits with its prey away from the farmer
//   all_across : every bit of move_pos is on the far bank
module crossing_checker
  import river_pkg::*;
#(
  parameter int unsigned N_ITEMS  = 3,
  parameter int unsigned BOAT_CAP = 1,
  parameter logic [N_ITEMS*N_ITEMS-1:0] CONFLICT = (N_ITEMS*N_ITEMS)'(CONFLICT_DEFAULT)
) (
  input  logic [N_ITEMS:0] pos,
  input  logic [N_ITEMS:0] move_pos,
  output logic             legal,
  output logic             conflict,
  output logic             all_across
);

  logic [N_ITEMS-1:0] changed;
  logic               farmer_flip;
  logic               ride_ok;
  logic               cap_ok;

  assign changed     = pos[N_ITEMS-1:0] ^ move_pos[N_ITEMS-1:0];
  assign farmer_flip = pos[N_ITEMS] ^ move_pos[N_ITEMS];
  assign cap_ok      = popcount(32'(changed)) <= BOAT_CAP;
  assign legal       = farmer_flip && ride_ok && cap_ok;
  assign all_across  = &move_pos;

  // Each moved item must leave from and arrive at the farmer's bank.
  always_comb begin
    ride_ok = 1'b1;
    for (int i = 0; i < int'(N_ITEMS); i++) begin
      if (changed[i] && ((pos[i] != pos[N_ITEMS]) || (move_pos[i] != move_pos[N_ITEMS]))) begin
        ride_ok = 1'b0;
      end
    end
  end

  // Any enabled predator/prey pair together on the bank opposite the farmer.
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < int'(N_ITEMS); i++) begin
      for (int j = 0; j < int'(N_ITEMS); j++) begin
        if (CONFLICT[i*int'(N_ITEMS)+j] && (move_pos[i] == move_pos[j]) &&
            (move_pos[N_ITEMS] != move_pos[i])) begin
          conflict = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/river_crossing_fsm.sv
// River crossing game controller.
//   clk, reset      : rising-edge clock, synchronous active-low reset
//   move_valid/pos  : move request handshake (move_ready high only in PLAY)
//   pos             : current bank vector {farmer, items}
//   move_cnt        : accepted legal moves
//   win/lose/over   : sticky outcome flags (over = lost on the move limit)
//   inv             : one-cycle pulse after an illegal handshake
module river_crossing_fsm
  import river_pkg::*;
#(
  parameter int unsigned N_ITEMS   = 3,
  parameter int unsigned BOAT_CAP  = 1,
  parameter int unsigned MAX_MOVES = 15,
  parameter int unsigned CNT_W     = 4,
  parameter logic [N_ITEMS*N_ITEMS-1:0] CONFLICT = (N_ITEMS*N_ITEMS)'(CONFLICT_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             move_valid,
  input  logic [N_ITEMS:0] move_pos,
  output logic             move_ready,
  output logic [N_ITEMS:0] pos,
  output logic [CNT_W-1:0] move_cnt,
  output logic             win,
  output logic             lose,
  output logic             over,
  output logic             inv
);

  state_t           state;
  logic             legal;
  logic             conflict;
  logic             all_across;
  logic [CNT_W-1:0] cnt_inc;
  logic             take;

  crossing_checker #(
    .N_ITEMS  (N_ITEMS),
    .BOAT_CAP (BOAT_CAP),
    .CONFLICT (CONFLICT)
  ) u_checker (
    .pos        (pos),
    .move_pos   (move_pos),
    .legal      (legal),
    .conflict   (conflict),
    .all_across (all_across)
  );

  assign cnt_inc = move_cnt + CNT_W'(1);
  assign take    = move_valid && move_ready;

  // State, counter and flags; outcome priority is win, conflict, move limit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= PLAY;
      move_ready <= 1'b1;
      pos        <= '0;
      move_cnt   <= '0;
      win        <= 1'b0;
      lose       <= 1'b0;
      over       <= 1'b0;
      inv        <= 1'b0;
    end else begin
      inv <= 1'b0;
      if (take && (state == PLAY)) begin
        if (!legal) begin
          inv <= 1'b1;
        end else begin
          pos      <= move_pos;
          move_cnt <= cnt_inc;
          if (all_across) begin
            state      <= WIN;
            move_ready <= 1'b0;
            win        <= 1'b1;
          end else if (conflict) begin
            state      <= LOSE;
            move_ready <= 1'b0;
            lose       <= 1'b1;
            over       <= 1'b0;
          end else if (cnt_inc == CNT_W'(MAX_MOVES)) begin
            state      <= LOSE;
            move_ready <= 1'b0;
            lose       <= 1'b1;
            over       <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_river_crossing_fsm.sv
// Directed table-driven bench for river_crossing_fsm (N_ITEMS=3, {farmer,fox,chicken,seed}).
module tb_river_crossing_fsm;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [3:0] mp;
    logic [3:0] pos;
    logic [3:0] cnt;
    logic       w;
    logic       l;
    logic       o;
    logic       i;
    logic       rdy;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       move_valid;
  logic [3:0] move_pos;
  logic       move_ready;
  logic [3:0] pos;
  logic [3:0] move_cnt;
  logic       win, lose, over, inv;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  river_crossing_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .move_valid (move_valid),
    .move_pos   (move_pos),
    .move_ready (move_ready),
    .pos        (pos),
    .move_cnt   (move_cnt),
    .win        (win),
    .lose       (lose),
    .over       (over),
    .inv        (inv)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic vld, input logic [3:0] mp,
                              input logic [3:0] p, input logic [3:0] c, input logic w,
                              input logic l, input logic o, input logic i, input logic rdy);
    vec_t v;
    v.rst = rst; v.vld = vld; v.mp = mp; v.pos = p; v.cnt = c;
    v.w = w; v.l = l; v.o = o; v.i = i; v.rdy = rdy;
    return v;
  endfunction

  // Drive one cycle, then compare all outputs 1 time unit after the edge.
  task automatic apply(input string name, input vec_t v);
    logic [12:0] got, exp;
    reset      = v.rst;
    move_valid = v.vld;
    move_pos   = v.mp;
    @(posedge clk);
    #1;
    got = {pos, move_cnt, win, lose, over, inv, move_ready};
    exp = {v.pos, v.cnt, v.w, v.l, v.o, v.i, v.rdy};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got pos=%b cnt=%0d w=%b l=%b o=%b inv=%b rdy=%b, want pos=%b cnt=%0d w=%b l=%b o=%b inv=%b rdy=%b",
               name, pos, move_cnt, win, lose, over, inv, move_ready,
               v.pos, v.cnt, v.w, v.l, v.o, v.i, v.rdy);
    end
  endtask

  initial begin
    reset      = 1'b0;
    move_valid = 1'b0;
    move_pos   = 4'b0000;

    // Solve the puzzle, then poke the WIN state.
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 4'b1010, 4'b1010, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 4'b0010, 4'b0010, 2, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 4'b1110, 4'b1110, 3, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 4'b0100, 4'b0100, 4, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 4'b1101, 4'b1101, 5, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 4'b0101, 4'b0101, 6, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 4'b1111, 4'b1111, 7, 1, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1, 1, 4'b0000, 4'b1111, 7, 1, 0, 0, 0, 0));
    // Fox leaves chicken with seed.
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 4'b1100, 4'b1100, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 4'b0100, 4'b1100, 1, 0, 1, 0, 0, 0));
    // Illegal requests: farmer stays, overloaded boat, no-op.
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 4'b0110, 4'b0000, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 4'b0110, 4'b0000, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 4'b1110, 4'b0000, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 4'b1110, 4'b0000, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 1, 4'b1010, 4'b1010, 1, 0, 0, 0, 0, 1));
    // Item not on the farmer's bank cannot be carried.
    vecs.push_back(mk(1, 1, 4'b0011, 4'b1010, 1, 0, 0, 0, 1, 1));
    // Mid-game reset beats a concurrent handshake.
    vecs.push_back(mk(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 4'b1010, 4'b1010, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 4'b0010, 4'b0010, 2, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 4'b1110, 4'b1110, 3, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 4'b1010, 4'b0000, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 4'b1010, 4'b0000, 0, 0, 0, 0, 0, 1));

    foreach (vecs[n]) apply($sformatf("vec%0d", n), vecs[n]);

    // Move limit: 15 shuttles of farmer+chicken, then a refused 16th request.
    apply("limit_reset", mk(0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 1));
    for (int k = 1; k <= 15; k++) begin
      logic [3:0] mp;
      logic [3:0] kc;
      logic       last;
      mp   = (k % 2 == 1) ? 4'b1010 : 4'b0000;
      kc   = 4'(k);
      last = (k == 15);
      apply($sformatf("limit%0d", k), mk(1, 1, mp, mp, kc, 0, last, last, 0, !last));
    end
    apply("limit_refuse", mk(1, 1, 4'b0000, 4'b1010, 15, 0, 1, 1, 0, 0));
    apply("limit_hold", mk(1, 0, 4'b0000, 4'b1010, 15, 0, 1, 1, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/river_crossing_fsm.md
Name: river_crossing_fsm

Overview:
- Parametrised successor to the four-input farmer/fox/chicken/seed puzzle controller.
- Supports N_ITEMS items plus a farmer, a configurable predator/prey conflict mask and a boat capacity.
- Moves are accepted through a valid/ready handshake, and the controller keeps a move counter with a move limit.
- Sits between the switch/button front-end and the display logic; reports win/lose/invalid as registered flags.

Parameters:
- N_ITEMS, 3, number of items excluding the farmer.
- BOAT_CAP, 1, maximum items carried per crossing, in addition to the farmer.
- MAX_MOVES, 15, number of accepted moves after which an unfinished game is lost.
- CNT_W, 4, move_cnt width; must hold MAX_MOVES.
- CONFLICT, 9'h088, N_ITEMS*N_ITEMS mask.
  - Bit i*N_ITEMS+j set means item i eats item j when both are on a bank without the farmer.
  - Default: item2 = fox eats item1 = chicken (bit 7); chicken eats item0 = seed (bit 3).

Ports:
- clk  in  1  single rising-edge clock.
- reset  in  1  synchronous, active-low reset: sampled on rising clk, asserted when 0.
- move_valid  in  1  move request present.
- move_pos  in  N_ITEMS+1  requested bank vector. Bit N_ITEMS = farmer, bits N_ITEMS-1:0 = items. 0 = start bank, 1 = far bank.
- move_ready  out  1  controller accepts a move this cycle.
- pos  out  N_ITEMS+1  current bank vector.
- move_cnt  out  CNT_W  count of accepted legal moves.
- win  out  1  game won (sticky).
- lose  out  1  game lost (sticky).
- over  out  1  loss was caused by the move limit (sticky).
- inv  out  1  one-cycle pulse: last handshake was an illegal move.

Behaviour:
- Reset (reset==0 at a rising edge):
  - pos=0, move_cnt=0, win=lose=over=inv=0, state=PLAY.
  - Overrides any concurrent handshake; usable mid-game.
- States:
  - PLAY: move_ready=1.
  - WIN: move_ready=0; move_valid ignored, no inv.
  - LOSE: move_ready=0; move_valid ignored, no inv.
  - WIN and LOSE are terminal until reset.
- Handshake: a move is taken when move_valid && move_ready at a rising edge. At most one move per cycle.
- A move is legal iff all of the following hold:
  - the farmer bit flips;
  - every changed item bit was equal to the old farmer bit and equals the new farmer bit;
  - popcount(changed item bits) <= BOAT_CAP.
- A no-op request (move_pos==pos) is illegal.
- Illegal move: pos and move_cnt unchanged; inv=1 for exactly the next cycle, then 0.
- Legal move, 1-cycle latency: pos<=move_pos and move_cnt<=move_cnt+1. Outcome is computed combinationally from move_pos and the incremented count, then registered in the same edge:
  1. If all bits of move_pos are 1: win=1, state=WIN. Win takes priority over the move limit.
  2. Else if any i,j with CONFLICT[i*N+j]=1 have items i and j on the same bank and the farmer on the other bank: lose=1, over=0, state=LOSE.
  3. Else if move_cnt+1 == MAX_MOVES: lose=1, over=1, state=LOSE.
  4. Else remain in PLAY.
- inv is 0 on every cycle not following an illegal handshake.
- move_cnt never wraps: the limit is reached before overflow because CNT_W holds MAX_MOVES.
- win and lose are never both 1.

Decomposition:
- Shared package river_pkg:
  - state typedef {PLAY, WIN, LOSE};
  - default conflict mask constant;
  - popcount function.
- Sub-module crossing_checker, purely combinational, parametrised on N_ITEMS/BOAT_CAP/CONFLICT.
  - Inputs: pos, move_pos.
  - Outputs: legal, conflict, all_across.
- Top level holds the state register, counter and flags.

Test Plan (N_ITEMS=3, bit order {farmer,fox,chicken,seed}):
1. After reset, hand-shake 1010,0010,1110,0100,1101,0101,1111, one per cycle → after the 7th edge: pos=1111, win=1, move_cnt=7, move_ready=0, lose=0.
2. From 0000, request 1100 → next cycle: pos=1100, lose=1, over=0, move_cnt=1, move_ready=0 (chicken with seed on the start bank).
3. From 0000, request 0110 (farmer stays), then 1110 (two items, BOAT_CAP=1) → inv pulses 1 cycle after each request; pos=0000, move_cnt=0 throughout.
4. Alternate 1010/0000 for 15 legal moves → after the 15th edge: pos=1010, lose=1, over=1, move_cnt=15; a 16th request is not accepted.
5. After 3 legal moves, drive reset=0 for 1 cycle with move_valid=1, move_pos=1010 → next cycle: pos=0000, move_cnt=0, all flags 0, move_ready=1.
6. In WIN state, drive move_valid=1 with move_pos=0000 for 4 cycles → pos, move_cnt and win unchanged; inv stays 0.
